uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 131 +++++++++++++
 tb/tb_uart_tx_buf.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered UART transmitter, 8N1 by default.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_buf #(
    parameter int DEPTH = 16
) (
    input  logic                   msoc_clk,
    input  logic                   rstn,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic [15:0]            baud,
    input  logic                   wrerr_clr,
    output logic                   uart_tx,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   wrerr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t        state_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   cnt_q, eff_q, eff_d;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q, head;
    logic          tx_q, wrerr_q;
    logic          push, drop, pop, bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    assign full    = count_q == FULL_CNT;
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign busy    = state_q != IDLE;
    assign wrerr   = wrerr_q;
    assign uart_tx = tx_q;
    assign push    = wr_en && !full;
    assign drop    = wr_en && full;
    assign head    = mem_q[rptr_q];
    assign eff_d   = baud < 16'd2 ? 16'd2 : baud;
    assign bit_end = cnt_q == eff_q - 16'd1;
    // A dropped write freezes the FIFO, so it also holds off a pop that cycle.
    assign pop     = !empty && !drop && (state_q == IDLE || (state_q == STOP && bit_end));
    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            wrerr_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            wrerr_q <= drop || (wrerr_q && !wrerr_clr);
        end
    end

    always_ff @(posedge msoc_clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            eff_q   <= 16'd2;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
            cnt_q   <= '0;
            eff_q   <= eff_d;
            bit_q   <= '0;
            shift_q <= head;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^head;
`endif
        end else if (state_q != IDLE) begin
            cnt_q <= bit_end ? '0 : cnt_q + 16'd1;
            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                    DATA: begin
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
`endif
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: randomized and directed bench for uart_tx_buf against a queue-based line model.
module tb_uart_tx_buf;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    logic        clk = 1'b0, rstn = 1'b0, wr_en = 1'b0, wrerr_clr = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [15:0] baud = 16'd4;
    logic        uart_tx, full, empty, busy, wrerr;
    logic [4:0]  count;
    int total = 0, bad = 0;

    uart_tx_buf #(.DEPTH(DEPTH)) dut (
        .msoc_clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .baud(baud),
        .wrerr_clr(wrerr_clr), .uart_tx(uart_tx), .full(full), .empty(empty),
        .count(count), .busy(busy), .wrerr(wrerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a byte queue for the FIFO and a per-cycle queue of line levels for the frame in flight.
    logic [7:0]  mq[$];
    bit          wave[$];
    logic        m_tx = 1'b1, m_busy = 1'b0, m_wrerr = 1'b0, m_drop;
    logic [7:0]  m_d;
    logic [10:0] fr;
    int          e;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            wave.delete();
            m_tx = 1'b1;
            m_busy = 1'b0;
            m_wrerr = 1'b0;
        end else begin
            m_drop = wr_en && mq.size() == DEPTH;
            if (wave.size() == 0 && mq.size() != 0 && !m_drop) begin
                m_d = mq.pop_front();
                e = baud < 16'd2 ? 2 : int'(baud);
`ifdef UART_TX_PARITY_EN
                fr = {1'b1, ^m_d, m_d, 1'b0};
`else
                fr = {2'b11, m_d, 1'b0};
`endif
                for (int i = 0; i < FB; i++)
                    for (int j = 0; j < e; j++) wave.push_back(fr[i]);
            end
            if (wr_en && !m_drop) mq.push_back(wr_data);
            m_busy = wave.size() != 0;
            m_tx = m_busy ? wave.pop_front() : 1'b1;
            m_wrerr = m_drop ? 1'b1 : (wrerr_clr ? 1'b0 : m_wrerr);
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("m_tx", uart_tx, m_tx);
            chk("m_busy", busy, m_busy);
            chk("m_count", count, mq.size());
            chk("m_full", full, mq.size() == DEPTH);
            chk("m_empty", empty, mq.size() == 0);
            chk("m_wrerr", wrerr, m_wrerr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int w = 0;
        while ((busy || !empty) && w < bound) begin step(); w++; end
        chk("idle_timeout", w < bound, 1);
    endtask

    task automatic low_run(output int len);
        int w = 0;
        len = 0;
        while (uart_tx !== 1'b0 && w < 5000) begin step(); w++; end
        while (uart_tx === 1'b0 && len < 5000) begin step(); len++; end
    endtask

    task automatic frame_cap(input logic [7:0] d, input logic [15:0] b, output logic [63:0] pat, output int nb);
        pat = '0;
        nb = 0;
        baud = b;
        wr_data = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        chk("cap_count", count, 1);
        for (int k = 0; k < FB * int'(b); k++) begin
            step();
            if (k == 0) chk("cap_empty", empty, 1);
            pat[k] = uart_tx;
            if (busy) nb++;
        end
        step();
        chk("cap_tail_busy", busy, 0);
        chk("cap_tail_tx", uart_tx, 1);
    endtask

    initial begin
        logic [63:0] pat;
        int nb, maxc, l1, l2;
        #10000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pat;
        int nb, maxc, l1, l2;
        repeat (3) step();
        chk("rst_tx", uart_tx, 1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrerr", wrerr, 0);
        @(negedge clk) rstn = 1'b1;
        step();

        // single frame, 4 cycles per bit
        frame_cap(8'h55, 16'd4, pat, nb);
`ifdef UART_TX_PARITY_EN
        chk("v1_pattern", pat, 64'hF00F0F0F0F0);
`else
        chk("v1_pattern", pat, 64'hF0F0F0F0F0);
`endif
        chk("v1_busy_cycles", nb, FB * 4);

        // three back-to-back frames
        baud = 16'd2;
        nb = 0;
        maxc = 0;
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = i == 0 ? 8'hA3 : (i == 1 ? 8'h0F : 8'hFF);
            step();
            if (busy) nb++;
            if (int'(count) > maxc) maxc = int'(count);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 500 && busy; i++) begin
            step();
            if (busy) nb++;
            if (int'(count) > maxc) maxc = int'(count);
        end
        chk("v2_busy_cycles", nb, 3 * FB * 2);
        chk("v2_peak_count", maxc, 2);
        chk("v2_busy_end", busy, 0);

        // baud 0 and 1 clamp to 2-cycle bits; mid-frame baud change
        for (int b = 0; b < 2; b++) begin
            baud = 16'(b);
            wr_data = 8'hFF;
            wr_en = 1'b1;
            step();
            wr_en = 1'b0;
            low_run(l1);
            chk(b == 0 ? "v4_baud0_bit" : "v4_baud1_bit", l1, 2);
            wait_idle(500);
        end
        baud = 16'd3;
        wr_data = 8'hFF;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        low_run(l1);
        baud = 16'd5;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        low_run(l2);
        chk("v4_old_baud", l1, 3);
        chk("v4_new_baud", l2, 5);
        wait_idle(500);

        // overflow: 18 writes into a 16-deep FIFO at slow baud
        baud = 16'd100;
        nb = 0;
        wr_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_data = 8'(i + 1);
            step();
            if (busy) nb++;
        end
        wr_en = 1'b0;
        chk("v3_full", full, 1);
        chk("v3_count", count, 16);
        chk("v3_wrerr", wrerr, 1);
        wrerr_clr = 1'b1;
        step();
        if (busy) nb++;
        wrerr_clr = 1'b0;
        chk("v3_wrerr_clr", wrerr, 0);
        for (int i = 0; i < 20000 && busy; i++) begin
            step();
            if (busy) nb++;
        end
        chk("v3_busy_cycles", nb, 17 * FB * 100);

        // reset mid-frame during bit 4 with bytes queued
        baud = 16'd4;
        wr_data = 8'h00;
        wr_en = 1'b1;
        repeat (3) step();
        wr_en = 1'b0;
        repeat (20) step();
        chk("v5_pre_tx", uart_tx, 0);
        #2 rstn = 1'b0;
        #1;
        chk("v5_tx", uart_tx, 1);
        chk("v5_count", count, 0);
        chk("v5_busy", busy, 0);
        chk("v5_empty", empty, 1);
        @(negedge clk) rstn = 1'b1;
        repeat (100) step();
        chk("v5_after_busy", busy, 0);
        chk("v5_after_tx", uart_tx, 1);

`ifdef UART_TX_PARITY_EN
        frame_cap(8'h07, 16'd4, pat, nb);
        chk("v6_par1", pat, 64'hFF00000FFF0);
        chk("v6_busy_cycles", nb, 44);
        frame_cap(8'h03, 16'd4, pat, nb);
        chk("v6_par0", pat, 64'hF0000000FF0);
`endif

        // random traffic, alternating heavy and light write phases
        for (int i = 0; i < 4000; i++) begin
            wr_en = ((i / 500) % 2 == 0) ? ($urandom_range(1) == 0) : ($urandom_range(11) == 0);
            wr_data = 8'($urandom);
            wrerr_clr = $urandom_range(15) == 0;
            if ($urandom_range(31) == 0) baud = 16'($urandom_range(5));
            step();
        end
        wr_en = 1'b0;
        wrerr_clr = 1'b0;
        wait_idle(5000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
